// File: rtl/mips_pkg.sv
// Shared defaults for the MIPS core register file and its clear-sweep state encoding.
package mips_pkg;
  localparam int WIDTH   = 32;
  localparam int REGSIZE = 32;
  localparam int R_WIDTH = $clog2(REGSIZE);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Bundled read/write/issue signals of the multi-port register file.
interface regfile_mp_if #(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int AW    = mips_pkg::R_WIDTH,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  // Protocol: no back-pressure. Every wr_en/iss_en seen at a posedge while ready=1 is
  // taken in that cycle; while ready=0 they are ignored. Reads are combinational.
  logic                 ready;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_data;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for hazard detection: issue sets, write-back clears, set wins.
module regfile_scoreboard #(
  parameter int DEPTH    = mips_pkg::REGSIZE,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);
  import mips_pkg::*;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (iss_en) busy_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // A write-back in flight means the value is already available via bypass,
  // unless a new producer claims the same register this cycle.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && !(ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0)) begin
        rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW] &&
                !(iss_en && iss_addr == rd_addr[i*AW +: AW]))
              rd_busy[i] = 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset clear sweep, write bypass and busy scoreboard.
module regfile_mp #(
  parameter int WIDTH    = mips_pkg::WIDTH,
  parameter int DEPTH    = mips_pkg::REGSIZE,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_mp_if.slave         bus,
  output mips_pkg::rf_state_t dbg_state
);
  import mips_pkg::*;

  localparam int AW = $clog2(DEPTH);

  rf_state_t      state_q;
  rf_state_t      state_d;
  logic [AW-1:0]  ptr_q;
  logic [AW-1:0]  ptr_d;
  logic           sweep_we;
  logic           run;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [NRD*WIDTH-1:0] rd_data_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sweep_we = 1'b0;
    case (state_q)
      CLEAR: begin
        sweep_we = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign run       = (state_q == RUN);
  assign bus.ready = run;
  assign dbg_state = state_q;

  // Ascending port order makes the highest-index port win on address collisions.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweep_we) begin
        mem[ptr_q] <= '0;
      end else if (run) begin
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && !(ZERO_REG != 0 && bus.wr_addr[j*AW +: AW] == '0))
            mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NRD; i++) begin
      if (run && !(ZERO_REG != 0 && bus.rd_addr[i*AW +: AW] == '0)) begin
        rd_data_c[i*WIDTH +: WIDTH] = mem[bus.rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])
              rd_data_c[i*WIDTH +: WIDTH] = bus.wr_data[j*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign bus.rd_data = rd_data_c;

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .NRD     (NRD),
    .NWR     (NWR),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .iss_en  (bus.iss_en),
    .iss_addr(bus.iss_addr),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .rd_addr (bus.rd_addr),
    .rd_busy (bus.rd_busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on/off) share stimulus and are checked against an array model.
module tb_regfile_mp;
  import mips_pkg::*;

  localparam int W   = 32;
  localparam int D   = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*W-1:0]  wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;

  regfile_mp_if #(.WIDTH(W), .AW(AW), .NRD(NRD), .NWR(NWR)) bus_a ();
  regfile_mp_if #(.WIDTH(W), .AW(AW), .NRD(NRD), .NWR(NWR)) bus_b ();
  rf_state_t dbg_a;
  rf_state_t dbg_b;

  assign bus_a.rd_addr  = rd_addr;
  assign bus_a.wr_en    = wr_en;
  assign bus_a.wr_addr  = wr_addr;
  assign bus_a.wr_data  = wr_data;
  assign bus_a.iss_en   = iss_en;
  assign bus_a.iss_addr = iss_addr;
  assign bus_b.rd_addr  = rd_addr;
  assign bus_b.wr_en    = wr_en;
  assign bus_b.wr_addr  = wr_addr;
  assign bus_b.wr_data  = wr_data;
  assign bus_b.iss_en   = iss_en;
  assign bus_b.iss_addr = iss_addr;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .dbg_state(dbg_a));
  regfile_mp #(.WIDTH(W), .DEPTH(D), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .dbg_state(dbg_b));

  // reference model: architectural registers, busy flags, sweep progress
  logic [W-1:0] m_reg [D];
  bit           m_busy [D];
  bit           m_ready = 0;
  bit           m_valid = 0;
  int           m_cnt   = 0;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rda(int p);
    return rd_addr[p*AW +: AW];
  endfunction

  function automatic logic [W-1:0] exp_data(int p, bit byp);
    logic [W-1:0] r;
    if (!m_ready || rda(p) == 0) return '0;
    r = m_reg[rda(p)];
    if (byp)
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == rda(p)) r = wr_data[j*W +: W];
    return r;
  endfunction

  function automatic logic exp_busy(int p, bit byp);
    bit hit = 0;
    if (!m_ready || rda(p) == 0) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == rda(p)) hit = 1;
    if (byp && hit && !(iss_en && iss_addr == rda(p))) return 1'b0;
    return m_busy[rda(p)];
  endfunction

  task automatic model_clock();
    if (!rst_n) begin
      m_ready = 0;
      m_cnt   = 0;
      foreach (m_busy[k]) m_busy[k] = 0;
      m_valid = 1;
    end else if (!m_ready) begin
      m_reg[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == D) m_ready = 1;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m_reg[wr_addr[j*AW +: AW]] = wr_data[j*W +: W];
      for (int j = 0; j < NWR; j++)
        if (wr_en[j]) m_busy[wr_addr[j*AW +: AW]] = 0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NRD; p++) begin
      exp_q.push_back(exp_data(p, 1));
      exp_q.push_back(exp_data(p, 0));
    end
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("a_rd%0d_r%0d", p, rda(p)), bus_a.rd_data[p*W +: W], exp_q.pop_front());
      chk($sformatf("b_rd%0d_r%0d", p, rda(p)), bus_b.rd_data[p*W +: W], exp_q.pop_front());
      chk($sformatf("a_busy%0d_r%0d", p, rda(p)), W'(bus_a.rd_busy[p]), W'(exp_busy(p, 1)));
      chk($sformatf("b_busy%0d_r%0d", p, rda(p)), W'(bus_b.rd_busy[p]), W'(exp_busy(p, 0)));
    end
    chk("a_ready", W'(bus_a.ready), W'(m_ready));
    chk("b_ready", W'(bus_b.ready), W'(m_ready));
    chk("a_state", W'(dbg_a), W'(m_ready ? RUN : CLEAR));
  endtask

  // driver tasks
  task automatic tick();
    #1;
    if (m_valid) check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
  endtask

  task automatic set_wr(int p, logic [AW-1:0] a, logic [W-1:0] d);
    wr_en[p]          = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*W +: W]   = d;
  endtask

  task automatic rand_inputs();
    wr_en    = NWR'($urandom_range(0, 3));
    for (int j = 0; j < NWR; j++) begin
      wr_addr[j*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D-1));
      wr_data[j*W +: W]   = $urandom;
    end
    iss_en   = 1'($urandom_range(0, 1));
    iss_addr = AW'($urandom_range(0, 7));
    for (int p = 0; p < NRD; p++)
      rd_addr[p*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, D-1));
  endtask

  task automatic wait_ready(string tag, bit noisy);
    int n = 0;
    while (bus_a.ready !== 1'b1 && n < 40) begin
      if (noisy) rand_inputs();
      tick();
      n++;
    end
    idle();
    chk(tag, W'(n), W'(D));
  endtask

  task automatic read_all();
    idle();
    for (int i = 0; i < D; i++) begin
      rd_addr = {AW'(D - 1 - i), AW'(i)};
      tick();
    end
  endtask

  initial begin
    idle();
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    @(negedge clk);
    repeat (3) tick();
    rst_n = 1'b1;
    wait_ready("ready_latency", 0);
    read_all();

    // r5 write then read on port 1; r0 write dropped
    set_wr(0, 5'd5, 32'hDEADBEEF); tick(); idle();
    rd_addr = {5'd5, 5'd0}; tick();
    set_wr(0, 5'd0, 32'h00001234); rd_addr = {5'd0, 5'd0}; tick(); idle(); tick();

    // same-cycle bypass of r7 (a sees new, b sees old)
    set_wr(0, 5'd7, 32'h01010101); tick(); idle();
    set_wr(0, 5'd7, 32'hA5A5A5A5); rd_addr = {5'd7, 5'd7}; tick(); idle(); tick();

    // both ports hit r3: port 1 wins
    set_wr(0, 5'd3, 32'h11); set_wr(1, 5'd3, 32'h22); rd_addr = {5'd3, 5'd3}; tick(); idle(); tick();

    // scoreboard
    rd_addr = {5'd9, 5'd9};
    iss_en = 1'b1; iss_addr = 5'd9; tick(); idle(); tick();
    set_wr(0, 5'd9, 32'h99); tick(); idle(); tick();
    iss_en = 1'b1; iss_addr = 5'd9; set_wr(1, 5'd9, 32'h98); tick(); idle(); tick();
    rd_addr = {5'd0, 5'd0};
    iss_en = 1'b1; iss_addr = 5'd0; tick(); idle(); tick();

    repeat (400) begin
      rand_inputs();
      tick();
    end

    // reset pulse in the middle of a sweep, writes attempted throughout
    idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (10) begin
      rand_inputs();
      tick();
    end
    idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    wait_ready("ready_after_restart", 1);
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
